// File: rtl/fire2_3_expand_1_sched_if.sv
// Bundle of request, sample, acknowledge and address/strobe signals shared
// between the expand-1 scheduler and its surroundings.
interface fire2_3_expand_1_sched_if #(
  parameter int IA_W = 16,
  parameter int OA_W = 12
);
  logic            req_2;
  logic            req_3;
  logic            sample;
  logic            ram_ack_2;
  logic            ram_ack_3;
  logic            fire2_expand_1_en;
  logic            fire3_expand_1_en;
  logic [IA_W-1:0] ifm_addr;
  logic [OA_W-1:0] ofm_addr;
  logic            ofm_we_2;
  logic            ofm_we_3;
  logic            done_2;
  logic            done_3;
  logic            busy;
  logic            err;

  // Layer chain / array side: issues requests and samples, observes outputs.
  modport master (
    output req_2, req_3, sample, ram_ack_2, ram_ack_3,
    input  fire2_expand_1_en, fire3_expand_1_en, ifm_addr, ofm_addr,
           ofm_we_2, ofm_we_3, done_2, done_3, busy, err
  );

  // Scheduler side.
  modport slave (
    input  req_2, req_3, sample, ram_ack_2, ram_ack_3,
    output fire2_expand_1_en, fire3_expand_1_en, ifm_addr, ofm_addr,
           ofm_we_2, ofm_we_3, done_2, done_3, busy, err
  );
endinterface

// File: rtl/fire2_3_expand_1_sched.sv
// Arbiter and sequencer for the shared fire2/fire3 expand-1x1 MAC array.
// Grants the array to one layer at a time (fire2 wins ties), walks the
// input-feature-map addresses, strobes output writes on each array sample,
// then waits for the output RAM acknowledge before reporting completion.
module fire2_3_expand_1_sched #(
  parameter int WOUT = 64,
  parameter int CHIN = 16,
  parameter int IA_W = $clog2(WOUT*WOUT*CHIN),
  parameter int OA_W = $clog2(WOUT*WOUT)
) (
  input logic                        clk,
  input logic                        rst,
  fire2_3_expand_1_sched_if.slave    bus
);

  localparam int NPIX = WOUT * WOUT;
  localparam int SW   = $clog2(CHIN + 1);

  localparam logic [SW-1:0]   SLOT_STALL = SW'(CHIN);
  localparam logic [SW-1:0]   SLOT_LAST  = SW'(CHIN - 1);
  localparam logic [OA_W-1:0] PIX_LAST   = OA_W'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, RUN2, ACK2, RUN3, ACK3} state_e;

  state_e          state_q, state_d;
  logic            pend_2_q, pend_2_d;
  logic            pend_3_q, pend_3_d;
  logic [SW-1:0]   s_q, s_d;
  logic [OA_W-1:0] p_q, p_d;
  logic [IA_W-1:0] ifm_addr_q, ifm_addr_d;
  logic [OA_W-1:0] ofm_addr_q, ofm_addr_d;
  logic            en_2_q, en_2_d;
  logic            en_3_q, en_3_d;
  logic            done_2_q, done_2_d;
  logic            done_3_q, done_3_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  // Next-state logic: request capture, arbitration, counters and completion.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    pend_2_d   = pend_2_q;
    pend_3_d   = pend_3_q;
    s_d        = s_q;
    p_d        = p_q;
    ifm_addr_d = ifm_addr_q;
    ofm_addr_d = ofm_addr_q;
    done_2_d   = 1'b0;
    done_3_d   = 1'b0;
    err_d      = err_q;

    // A request for the layer already holding the array is dropped and flagged;
    // a request for the other layer waits in its pending flag.
    if (bus.req_2) begin
      if (state_q == RUN2 || state_q == ACK2) err_d    = 1'b1;
      else                                    pend_2_d = 1'b1;
    end
    if (bus.req_3) begin
      if (state_q == RUN3 || state_q == ACK3) err_d    = 1'b1;
      else                                    pend_3_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_2_q) begin
          state_d    = RUN2;
          pend_2_d   = 1'b0;
          s_d        = '0;
          p_d        = '0;
          ifm_addr_d = '0;
        end else if (pend_3_q) begin
          state_d    = RUN3;
          pend_3_d   = 1'b0;
          s_d        = '0;
          p_d        = '0;
          ifm_addr_d = '0;
        end
      end

      RUN2, RUN3: begin
        // Slot/pixel walk; the address holds on the stall slot and the whole
        // walk freezes on the stall slot of the final pixel.
        if (!(p_q == PIX_LAST && s_q == SLOT_STALL)) begin
          if (s_q == SLOT_STALL) begin
            s_d        = '0;
            p_d        = p_q + OA_W'(1);
            ifm_addr_d = ifm_addr_q + IA_W'(1);
          end else begin
            s_d = s_q + SW'(1);
            if (s_q != SLOT_LAST) ifm_addr_d = ifm_addr_q + IA_W'(1);
          end
        end
        // Each sample writes one pixel; the last pixel's sample ends the run.
        if (bus.sample) begin
          ofm_addr_d = ofm_addr_q + OA_W'(1);
          if (ofm_addr_q == PIX_LAST) state_d = (state_q == RUN2) ? ACK2 : ACK3;
        end
      end

      ACK2: begin
        if (bus.ram_ack_2) begin
          state_d    = IDLE;
          done_2_d   = 1'b1;
          ofm_addr_d = '0;
        end
      end

      ACK3: begin
        if (bus.ram_ack_3) begin
          state_d    = IDLE;
          done_3_d   = 1'b1;
          ofm_addr_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    en_2_d = (state_d == RUN2);
    en_3_d = (state_d == RUN3);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; an asynchronous reset aborts any layer.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: asynchronous active-low reset clears every flop, so outputs drop
    // to zero immediately without waiting for a clock edge.
    if (!rst) begin
      state_q    <= IDLE;
      pend_2_q   <= 1'b0;
      pend_3_q   <= 1'b0;
      s_q        <= '0;
      p_q        <= '0;
      ifm_addr_q <= '0;
      ofm_addr_q <= '0;
      en_2_q     <= 1'b0;
      en_3_q     <= 1'b0;
      done_2_q   <= 1'b0;
      done_3_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pend_2_q   <= pend_2_d;
      pend_3_q   <= pend_3_d;
      s_q        <= s_d;
      p_q        <= p_d;
      ifm_addr_q <= ifm_addr_d;
      ofm_addr_q <= ofm_addr_d;
      en_2_q     <= en_2_d;
      en_3_q     <= en_3_d;
      done_2_q   <= done_2_d;
      done_3_q   <= done_3_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Write strobes follow the sample in the same cycle, gated by the owner.
  assign bus.ofm_we_2          = bus.sample && (state_q == RUN2);
  assign bus.ofm_we_3          = bus.sample && (state_q == RUN3);
  assign bus.fire2_expand_1_en = en_2_q;
  assign bus.fire3_expand_1_en = en_3_q;
  assign bus.ifm_addr          = ifm_addr_q;
  assign bus.ofm_addr          = ofm_addr_q;
  assign bus.done_2            = done_2_q;
  assign bus.done_3            = done_3_q;
  assign bus.busy              = busy_q;
  assign bus.err               = err_q;

endmodule

// File: doc/fire2_3_expand_1_sched.md
# fire2_3_expand_1_sched

Sequencer and arbiter for the shared fire2/fire3 expand-1×1 MAC array. It grants the array to one layer at a time (fire2 has fixed priority) and drives that layer's enable. It generates input-feature-map read addresses and output write strobes/addresses from the array's sample strobe. It holds the layer until the output RAM acknowledges, then reports completion to the top-level layer chain.

## Interface
- WOUT, 64, output feature-map width/height; pixels per layer = WOUT*WOUT
- CHIN, 16, input channels per pixel; array consumes CHIN+1 cycles per pixel
- IA_W, $clog2(WOUT*WOUT*CHIN), ifm_addr width (16 at defaults)
- OA_W, $clog2(WOUT*WOUT), ofm_addr width (12 at defaults)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_2  in  1  one-cycle start request for fire2 expand-1
- req_3  in  1  one-cycle start request for fire3 expand-1
- sample  in  1  array output-valid strobe (one cycle per completed pixel)
- ram_ack_2  in  1  fire2 output RAM has committed all pixels (level or pulse)
- ram_ack_3  in  1  same for fire3
- fire2_expand_1_en  out  1  array enable, fire2 selected
- fire3_expand_1_en  out  1  array enable, fire3 selected
- ifm_addr  out  IA_W  ifm read address, pixel*CHIN + channel
- ofm_addr  out  OA_W  output pixel index for current write
- ofm_we_2  out  1  write strobe, fire2 output RAM
- ofm_we_3  out  1  write strobe, fire3 output RAM
- done_2  out  1  one-cycle pulse, fire2 layer complete
- done_3  out  1  one-cycle pulse, fire3 layer complete
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky: a request for the layer currently owning the array was dropped

## Operation
- States: IDLE, RUN2, ACK2, RUN3, ACK3.
- pend_2/pend_3 are set by req_x and cleared on entry to RUN_x. A req_x arriving in RUN_x/ACK_x is dropped and sets err. A request for the other layer stays pending.
- IDLE: if pend_2, go to RUN2. Else if pend_3, go to RUN3. Both pending: RUN2 first.
- RUN_x: fire_x_en=1. Counters slot s (0..CHIN) and pixel p (0..WOUT*WOUT-1) start at 0 on entry.
  - s increments each cycle and wraps CHIN to 0, incrementing p.
  - ifm_addr = p*CHIN + min(s, CHIN-1); it is held on the stall slot s==CHIN.
  - After p=WOUT*WOUT-1, s=CHIN, counters freeze and ifm_addr holds the last address.
- sample in RUN_x: ofm_we_x=1 the same cycle (combinational from sample and state) with the current ofm_addr; ofm_addr increments on the next edge.
- The WOUT*WOUT-th sample in RUN_x goes to ACK_x on the next edge. fire_x_en drops in ACK_x.
- sample outside RUN states is ignored: no strobe, no count.
- ACK_x: wait for ram_ack_x. Then done_x pulses one cycle and the state returns to IDLE; ofm_addr clears to 0 on that edge.
- Never both enables at once. Never both ofm_we at once.
- ofm_addr wraps naturally at WOUT*WOUT (2^OA_W). Exit from RUN uses the sample count, not the wrap.

## Timing
- All outputs reset to 0: both enables, ifm_addr, ofm_addr, both we, both done, busy, err. State resets to IDLE; pend, s and p reset to 0.
- Reset mid-layer aborts immediately. No done is issued, and the layer must be re-requested.
- req_x at edge n, from IDLE: RUN_x and fire_x_en are high from edge n+1.
- First ifm_addr=0 appears with en. The address advances per s as specified.
- Typical first sample: CHIN+2 cycles after en rises (array latency). The scheduler does not depend on this; it counts samples only.
- ram_ack_x already high on entry to ACK_x: done_x pulses on the first ACK cycle +1 edge. Minimum ACK dwell is 1 cycle.
- req_x and sample in the same cycle: both are processed.
- req_3 in the same cycle as done_2: RUN3 starts on the next IDLE evaluation. Back-to-back latency is 1 IDLE cycle.

## Test plan
- WOUT=4, CHIN=2: pulse req_2; drive sample every 3 cycles ×16; ack 2 cycles after the 16th -> 16 ofm_we_2 strobes with addr 0..15, ifm_addr sequence 0,1,1,2,3,3,…,31,31, one done_2, en low, busy low.
- req_2 and req_3 in the same cycle -> fire2 runs fully, then 1 IDLE cycle, then fire3 runs. done_2 precedes done_3. The enables never overlap.
- req_2 pulsed again during RUN2 -> err=1 and stays 1, no second fire2 run. A concurrent req_3 still runs after fire2.
- ram_ack_2 held low 50 cycles after the last sample -> stays in ACK2, busy=1, both enables 0. Releasing ack -> done_2 next edge.
- rst asserted low after 7 samples of RUN3 -> all outputs 0 asynchronously, no done_3. A fresh req_3 restarts at ofm_addr 0, ifm_addr 0.
- sample pulsed in IDLE and ACK2 -> no ofm_we, ofm_addr unchanged.
